// File: rtl/char_movement_ctrl.sv
// Character movement controller: tick-driven horizontal walking with
// saturation, plus an IDLE/JUMP/FALL vertical state machine.
module char_movement_ctrl #(
    parameter logic [11:0] X_START     = 12'd400,
    parameter logic [11:0] Y_START     = 12'd500,
    parameter logic [11:0] X_MIN       = 12'd0,
    parameter logic [11:0] X_MAX       = 12'd760,
    parameter logic [11:0] Y_MIN       = 12'd0,
    parameter logic [11:0] Y_MAX       = 12'd500,
    parameter logic [11:0] JUMP_HEIGHT = 12'd100
) (
    input  logic        clk_40MHz,
    input  logic        rst,
    input  logic        movement_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    input  logic        on_platform,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [1:0]  state,
    output logic [11:0] jump_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_JUMP = 2'd1,
        ST_FALL = 2'd2,
        ST_BAD  = 2'd3
    } state_e;

    state_e      state_q,    state_d;
    logic [11:0] xpos_q,     xpos_d;
    logic [11:0] ypos_q,     ypos_d;
    logic [11:0] jump_cnt_q, jump_cnt_d;

    // Next-state and next-position computation for one movement step
    always_comb begin
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;
        state_d    = state_q;
        jump_cnt_d = jump_cnt_q;

        // Horizontal motion is independent of the vertical state
        if (btn_left && !btn_right) begin
            if (xpos_q > X_MIN) xpos_d = xpos_q - 12'd1;
        end else if (btn_right && !btn_left) begin
            if (xpos_q < X_MAX) xpos_d = xpos_q + 12'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (btn_jump) begin
                    // Launch step counts as the first ascent step
                    state_d    = ST_JUMP;
                    jump_cnt_d = '0;
                    if (ypos_q > Y_MIN) ypos_d = ypos_q - 12'd1;
                end else if (!on_platform && (ypos_q < Y_MAX)) begin
                    state_d = ST_FALL;
                    ypos_d  = ypos_q + 12'd1;
                end
            end
            ST_JUMP: begin
                // Apex is detected on the step that reaches it, so a jump
                // is exactly JUMP_HEIGHT ascent steps including the launch
                if ((jump_cnt_q >= JUMP_HEIGHT - 12'd1) || (ypos_q <= Y_MIN)) begin
                    state_d = ST_FALL;
                end else begin
                    ypos_d     = ypos_q - 12'd1;
                    jump_cnt_d = jump_cnt_q + 12'd1;
                    if ((jump_cnt_q + 12'd1 == JUMP_HEIGHT - 12'd1) ||
                        (ypos_q - 12'd1 == Y_MIN))
                        state_d = ST_FALL;
                end
            end
            ST_FALL: begin
                if (on_platform || (ypos_q >= Y_MAX)) begin
                    state_d    = ST_IDLE;
                    jump_cnt_d = '0;
                end else begin
                    // Land on the same step that reaches the floor
                    ypos_d = ypos_q + 12'd1;
                    if (ypos_q + 12'd1 >= Y_MAX) begin
                        state_d    = ST_IDLE;
                        jump_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_FALL;
            end
        endcase
    end

    // State registers advance only on movement ticks
    always_ff @(posedge clk_40MHz or posedge rst) begin
        if (rst) begin
            xpos_q     <= X_START;
            ypos_q     <= Y_START;
            state_q    <= ST_IDLE;
            jump_cnt_q <= '0;
        end else if (movement_tick) begin
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            state_q    <= state_d;
            jump_cnt_q <= jump_cnt_d;
        end
    end

    assign xpos     = xpos_q;
    assign ypos     = ypos_q;
    assign state    = state_q;
    assign jump_cnt = jump_cnt_q;

endmodule

// File: tb/tb_char_movement_ctrl.sv
// Scoreboard bench for char_movement_ctrl: three instances (defaults,
// raised ceiling, high start) share stimulus; the idle ones sit in reset.
`timescale 1ns/1ps
module tb_char_movement_ctrl;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  s;
        logic [11:0] c;
    } exp_t;

    localparam exp_t RST01 = '{x: 12'd400, y: 12'd500, s: 2'd0, c: 12'd0};
    localparam exp_t RST2  = '{x: 12'd400, y: 12'd300, s: 2'd0, c: 12'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic mt, bl, br, bj, op;
    logic [11:0] xa, ya, ca, xb, yb, cb, xc, yc, cc;
    logic [1:0]  sa, sb, sc;
    exp_t a0, a1, a2;

    assign a0 = {xa, ya, sa, ca};
    assign a1 = {xb, yb, sb, cb};
    assign a2 = {xc, yc, sc, cc};

    char_movement_ctrl dut_a (
        .clk_40MHz(clk), .rst(rst_a), .movement_tick(mt),
        .btn_left(bl), .btn_right(br), .btn_jump(bj), .on_platform(op),
        .xpos(xa), .ypos(ya), .state(sa), .jump_cnt(ca)
    );

    char_movement_ctrl #(.Y_MIN(12'd450)) dut_b (
        .clk_40MHz(clk), .rst(rst_b), .movement_tick(mt),
        .btn_left(bl), .btn_right(br), .btn_jump(bj), .on_platform(op),
        .xpos(xb), .ypos(yb), .state(sb), .jump_cnt(cb)
    );

    char_movement_ctrl #(.Y_START(12'd300)) dut_c (
        .clk_40MHz(clk), .rst(rst_c), .movement_tick(mt),
        .btn_left(bl), .btn_right(br), .btn_jump(bj), .on_platform(op),
        .xpos(xc), .ypos(yc), .state(sc), .jump_cnt(cc)
    );

    int    tests = 0;
    int    fails = 0;
    int    act   = 0;
    string nq[$];
    exp_t  q0[$], q1[$], q2[$];

    function automatic void cmp(string nm, int d, exp_t a, exp_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s dut%0d: got x=%0d y=%0d st=%0d cnt=%0d, expected x=%0d y=%0d st=%0d cnt=%0d",
                     nm, d, a.x, a.y, a.s, a.c, e.x, e.y, e.s, e.c);
        end
    endfunction

    function automatic exp_t mk(logic [11:0] x, logic [11:0] y, logic [1:0] s, logic [11:0] c);
        exp_t e;
        e = '{x: x, y: y, s: s, c: c};
        return e;
    endfunction

    // Immediate check of all instances; active one against e, others at reset
    task automatic check_all(input string nm, input exp_t e);
        cmp(nm, 0, a0, (act == 0) ? e : RST01);
        cmp(nm, 1, a1, (act == 1) ? e : RST01);
        cmp(nm, 2, a2, (act == 2) ? e : RST2);
    endtask

    // One movement tick with the expected post-tick outputs of the active DUT
    task automatic do_tick(input string nm, input logic l, input logic r, input logic j,
                           input logic p, input logic [11:0] ex, input logic [11:0] ey,
                           input logic [1:0] es, input logic [11:0] ec);
        exp_t e;
        e = mk(ex, ey, es, ec);
        @(negedge clk);
        bl = l; br = r; bj = j; op = p; mt = 1'b1;
        nq.push_back(nm);
        q0.push_back((act == 0) ? e : RST01);
        q1.push_back((act == 1) ? e : RST01);
        q2.push_back((act == 2) ? e : RST2);
        @(negedge clk);
        mt = 1'b0;
    endtask

    task automatic select(input int a);
        @(negedge clk);
        act   = a;
        rst_a = (a != 0);
        rst_b = (a != 1);
        rst_c = (a != 2);
    endtask

    // Monitor: every tick sampled on a rising edge yields one scoreboard entry
    initial begin
        forever begin
            @(posedge clk);
            if (mt === 1'b1) begin
                #1;
                if (nq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_underflow: got output with no expectation queued");
                end else begin
                    string nm;
                    nm = nq.pop_front();
                    cmp(nm, 0, a0, q0.pop_front());
                    cmp(nm, 1, a1, q1.pop_front());
                    cmp(nm, 2, a2, q2.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        mt = 1'b0; bl = 1'b0; br = 1'b0; bj = 1'b0; op = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        act = 0;
        #3;
        check_all("reset_initial", RST01);
        select(0);

        // Walking and button conflicts
        for (int k = 1; k <= 3; k++) do_tick("walk_right", 0, 1, 0, 0, 12'(400 + k), 500, 0, 0);
        for (int k = 1; k <= 3; k++) do_tick("walk_left", 1, 0, 0, 0, 12'(403 - k), 500, 0, 0);
        for (int k = 1; k <= 2; k++) do_tick("both_btns", 1, 1, 0, 0, 400, 500, 0, 0);

        // Buttons active but no tick: nothing may change
        @(negedge clk);
        bl = 1'b0; br = 1'b1; bj = 1'b1; op = 1'b0;
        repeat (1000) @(negedge clk);
        check_all("no_tick_hold", mk(400, 500, 0, 0));

        // Full jump and fall back to the floor
        do_tick("jump_launch", 0, 0, 1, 0, 400, 499, 1, 0);
        for (int k = 2; k <= 100; k++)
            do_tick("jump_ascent", 0, 0, 0, 0, 400, 12'(500 - k), (k == 100) ? 2'd2 : 2'd1, 12'(k - 1));
        for (int k = 101; k <= 200; k++)
            do_tick("jump_fall", 0, 0, 0, 0, 400, 12'(300 + k), (k == 200) ? 2'd0 : 2'd2,
                    (k == 200) ? 12'd0 : 12'd99);

        // Held jump relaunches; no double jump; reset aborts a jump
        do_tick("relaunch", 0, 0, 1, 0, 400, 499, 1, 0);
        do_tick("no_double_jump", 0, 0, 1, 0, 400, 498, 1, 1);
        @(negedge clk);
        #2 rst_a = 1'b1;
        #1 check_all("reset_mid_jump", RST01);
        @(negedge clk);
        rst_a = 1'b0;
        do_tick("post_reset_idle", 0, 0, 0, 0, 400, 500, 0, 0);

        // Horizontal saturation at both ends
        for (int k = 1; k <= 400; k++) do_tick("to_left_edge", 1, 0, 0, 0, 12'(400 - k), 500, 0, 0);
        for (int k = 1; k <= 5; k++) do_tick("sat_xmin", 1, 0, 0, 0, 0, 500, 0, 0);
        for (int k = 1; k <= 760; k++) do_tick("to_right_edge", 0, 1, 0, 0, 12'(k), 500, 0, 0);
        for (int k = 1; k <= 5; k++) do_tick("sat_xmax", 0, 1, 0, 0, 760, 500, 0, 0);
        for (int k = 1; k <= 3; k++) do_tick("both_at_max", 1, 1, 0, 0, 760, 500, 0, 0);

        // Raised ceiling, walking left during the jump, reset mid-fall
        select(1);
        do_tick("ceil_launch", 1, 0, 1, 0, 399, 499, 1, 0);
        for (int k = 2; k <= 50; k++)
            do_tick("ceil_ascent", 1, 0, 0, 0, 12'(400 - k), 12'(500 - k),
                    (k == 50) ? 2'd2 : 2'd1, 12'(k - 1));
        for (int k = 51; k <= 70; k++)
            do_tick("ceil_fall", 1, 0, 0, 0, 12'(400 - k), 12'(400 + k), 2, 49);
        @(negedge clk);
        #2 rst_b = 1'b1;
        #1 check_all("reset_mid_fall", RST01);
        @(negedge clk);
        rst_b = 1'b0;
        do_tick("ceil_post_reset", 0, 0, 0, 0, 400, 500, 0, 0);

        // Fall from 300 while walking right, land on a platform at 350
        select(2);
        for (int k = 1; k <= 50; k++)
            do_tick("plat_fall", 0, 1, 0, 0, 12'(400 + k), 12'(300 + k), 2, 0);
        do_tick("plat_land", 0, 0, 0, 1, 450, 350, 0, 0);
        do_tick("plat_hold", 0, 0, 0, 1, 450, 350, 0, 0);

        repeat (4) @(negedge clk);
        if (nq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", nq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/char_movement_ctrl.md
CHAR_MOVEMENT_CTRL -- requirements
Module: char_movement_ctrl

Interface
REQ-001 Parameter X_START, default 12'd400, SHALL be the reset x position in pixels.
REQ-002 Parameter Y_START, default 12'd500, SHALL be the reset y position in pixels (y grows downward).
REQ-003 Parameter X_MIN, default 12'd0, SHALL be the minimum allowed x.
REQ-004 Parameter X_MAX, default 12'd760, SHALL be the maximum allowed x.
REQ-005 Parameter Y_MIN, default 12'd0, SHALL be the jump ceiling (minimum y).
REQ-006 Parameter Y_MAX, default 12'd500, SHALL be the floor (maximum y).
REQ-007 Parameter JUMP_HEIGHT, default 12'd100, SHALL be the number of ascent steps per jump; legal range 1..4095.
REQ-008 clk_40MHz  input  1  system clock; all state changes on its rising edge.
REQ-009 rst  input  1  reset; asynchronous, active-high.
REQ-010 movement_tick  input  1  single-cycle step strobe from the movement timer; one step per high cycle.
REQ-011 btn_left  input  1  level; request a move left.
REQ-012 btn_right  input  1  level; request a move right.
REQ-013 btn_jump  input  1  level; request a jump.
REQ-014 on_platform  input  1  level; character feet rest on a platform at the current ypos.
REQ-015 xpos  output  12  registered character x.
REQ-016 ypos  output  12  registered character y.
REQ-017 state  output  2  registered FSM state: 0 IDLE, 1 JUMP, 2 FALL.
REQ-018 jump_cnt  output  12  registered ascent step counter.

Function
REQ-019 All updates SHALL occur only on rising edges where movement_tick=1; on all other edges every output SHALL hold.
REQ-020 Latency SHALL be one step: a tick sampled high at edge N produces new xpos/ypos/state visible after edge N.
REQ-021 Horizontal, per tick: btn_left=1 and btn_right=0 -> xpos-1, saturating at X_MIN; btn_right=1 and btn_left=0 -> xpos+1, saturating at X_MAX; both or neither -> hold.
REQ-022 Horizontal movement SHALL be independent of FSM state (allowed in IDLE, JUMP, FALL).
REQ-023 IDLE, per tick: btn_jump=1 -> JUMP, jump_cnt<=0, ypos-1 (skip decrement if ypos==Y_MIN); else on_platform=0 and ypos<Y_MAX -> FALL, ypos+1; else hold.
REQ-024 btn_jump SHALL take priority over falling in IDLE.
REQ-025 JUMP, per tick: ypos-1, jump_cnt+1; when jump_cnt==JUMP_HEIGHT-1 or ypos==Y_MIN, next state FALL and ypos SHALL NOT go below Y_MIN.
REQ-026 btn_jump SHALL be ignored in JUMP and FALL (no double jump); holding it in IDLE re-triggers a jump on the next tick after landing.
REQ-027 FALL, per tick: on_platform=1 or ypos>=Y_MAX -> IDLE, ypos held, jump_cnt<=0; else ypos+1, never exceeding Y_MAX.
REQ-028 on_platform SHALL be ignored in JUMP (character passes upward through platforms).
REQ-029 Arithmetic SHALL be 12-bit unsigned; no wrap-around of xpos or ypos in any state.
REQ-030 Unused state encoding 3 SHALL recover to FALL on the next tick.

Reset
REQ-031 While rst=1, asynchronously and regardless of clock: xpos=X_START, ypos=Y_START, state=IDLE, jump_cnt=0.
REQ-032 Reset asserted mid-jump or mid-fall SHALL abort the motion; first step after release SHALL follow IDLE rules.

Verification
REQ-033 Reset: assert rst between clock edges -> outputs 400/500/IDLE/0 immediately, before next clk_40MHz edge.
REQ-034 Full jump: defaults, on_platform=0, btn_jump high for one tick -> ypos 499..400 over 100 ticks, state FALL after tick 100, back to ypos 500/IDLE after 100 further ticks.
REQ-035 Saturation: xpos=0 with btn_left held 5 ticks -> xpos stays 0; xpos=760 with btn_right -> stays 760; both buttons -> xpos unchanged.
REQ-036 Platform landing: fall from ypos 300, on_platform raised when ypos==350 -> state IDLE, ypos 350 at that tick and held.
REQ-037 No tick: buttons active, movement_tick=0 for 1000 cycles -> no output changes.
REQ-038 Ceiling/reset mid-jump: Y_MIN=450 -> ascent stops at 450 then FALL; rst pulsed at ypos 470 -> 400/500/IDLE.
